// File: rtl/wb_ram_pkg.sv
// Shared constants and types for the multi-port Wishbone RAM.
//   WB_DW      - Wishbone data width
//   WB_SELW    - byte-select width
//   NPORTS_MAX - largest supported port count
//   port_idx_t - wide enough to name any port (and the arbiter pointer)
package wb_ram_pkg;

  localparam int unsigned WB_DW      = 32;
  localparam int unsigned WB_SELW    = 4;
  localparam int unsigned NPORTS_MAX = 8;

  typedef logic [2:0] port_idx_t;

endpackage

// File: rtl/wishbone_if.sv
// Pipelined Wishbone bus bundle.
// Ports:   clk_i, rst_ni - carried for bus completeness; the RAM clocks and resets from its own pins.
// Signals: addr, data_m (master->slave data), data_s (slave->master data), sel, we, cyc, stb,
//          ack, stall, err.
// Modports: master drives request fields; slave drives data_s/ack/stall/err.
interface wishbone_if
  import wb_ram_pkg::*;
(
  input logic clk_i,
  input logic rst_ni
);

  logic [31:0]        addr;
  logic [WB_DW-1:0]   data_m;
  logic [WB_DW-1:0]   data_s;
  logic [WB_SELW-1:0] sel;
  logic               we;
  logic               cyc;
  logic               stb;
  logic               ack;
  logic               stall;
  logic               err;

  // Clock/reset members are not consumed by any logic on this bus.
  logic unused_clk_rst;
  assign unused_clk_rst = clk_i ^ rst_ni;

  modport master (
    output addr, data_m, sel, we, cyc, stb,
    input  data_s, ack, stall, err
  );

  modport slave (
    input  addr, data_m, sel, we, cyc, stb,
    output data_s, ack, stall, err
  );

endinterface

// File: rtl/wb_rr_arb.sv
// Round-robin arbiter with rotating priority pointer.
// Ports: clk_i, rst_ni (async active-low), req[N] requests, gnt[N] one-hot grant (combinational).
// The search starts at ptr and ascends with wrap; after a grant to port g, ptr becomes (g+1) mod N.
module wb_rr_arb
  import wb_ram_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  port_idx_t      ptr_q, ptr_d;
  logic [2*N-1:0] req_dbl, gnt_dbl;
  logic [N-1:0]   req_rot, gnt_rot;
  logic           found;

  // Rotate requests so ptr lands at bit 0, pick the lowest set bit, rotate back.
  always_comb begin
    req_dbl = {req, req} >> ptr_q;
    req_rot = req_dbl[N-1:0];
    gnt_rot = '0;
    found   = 1'b0;
    for (int k = 0; k < int'(N); k++) begin
      if (req_rot[k] && !found) begin
        gnt_rot[k] = 1'b1;
        found      = 1'b1;
      end
    end
    gnt_dbl = {gnt_rot, gnt_rot} << ptr_q;
    gnt     = gnt_dbl[2*N-1:N];
  end

  always_comb begin
    ptr_d = ptr_q;
    for (int j = 0; j < int'(N); j++) begin
      if (gnt[j]) begin
        ptr_d = (j == int'(N) - 1) ? port_idx_t'(0) : port_idx_t'(j + 1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/wb_np_ram.sv
// N-port pipelined Wishbone RAM over one single-port byte-enabled array.
// Parameters: SIZE (words, power of two), NPORTS (1..8), INIT_ZERO (1 = array starts cleared).
// Ports: clk_i, rst_ni (async active-low), wb[NPORTS] Wishbone slave ports.
// One access per cycle is granted round-robin; ack (or err) follows one cycle later and carries
// the word as it was before any write in that access (read-first).
// Build option: WB_NP_RAM_ADDR_CHECK_EN - accesses at or above SIZE*4 do not write and return
// err; without it err is 0 and addresses alias modulo SIZE words.
module wb_np_ram
  import wb_ram_pkg::*;
#(
  parameter int unsigned SIZE      = 1024,
  parameter int unsigned NPORTS    = 2,
  parameter int unsigned INIT_ZERO = 1
) (
  input logic       clk_i,
  input logic       rst_ni,
  wishbone_if.slave wb [NPORTS]
);

  localparam int unsigned ADDR_WIDTH = $clog2(SIZE);

  logic [NPORTS-1:0]  req, gnt, accept, ack_q;
  logic [31:0]        addr_a [NPORTS];
  logic [WB_DW-1:0]   data_a [NPORTS];
  logic [WB_SELW-1:0] sel_a  [NPORTS];
  logic [NPORTS-1:0]  we_a;

  logic               acc_any;
  logic [31:0]        m_addr;
  logic [WB_DW-1:0]   m_data;
  logic [WB_SELW-1:0] m_sel;
  logic               m_we;
  logic               oob;
  logic               unused_addr;
  logic [ADDR_WIDTH-1:0] idx;
  logic [WB_SELW-1:0] be;
  logic [WB_DW-1:0]   rdata_q;

  for (genvar p = 0; p < NPORTS; p++) begin : g_in
    assign req[p]    = wb[p].cyc & wb[p].stb;
    assign addr_a[p] = wb[p].addr;
    assign data_a[p] = wb[p].data_m;
    assign sel_a[p]  = wb[p].sel;
    assign we_a[p]   = wb[p].we;
  end

  wb_rr_arb #(
    .N (NPORTS)
  ) u_arb (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .req    (req),
    .gnt    (gnt)
  );

  // Nothing is accepted while reset is held, so no write can slip through.
  assign accept = rst_ni ? gnt : '0;

  // Grant is one-hot, so an OR-mux selects the winning port's request.
  always_comb begin
    acc_any = |accept;
    m_addr  = '0;
    m_data  = '0;
    m_sel   = '0;
    m_we    = 1'b0;
    for (int p = 0; p < int'(NPORTS); p++) begin
      if (accept[p]) begin
        m_addr = m_addr | addr_a[p];
        m_data = m_data | data_a[p];
        m_sel  = m_sel | sel_a[p];
        m_we   = m_we | we_a[p];
      end
    end
  end

  assign idx = m_addr[ADDR_WIDTH+1:2];

`ifdef WB_NP_RAM_ADDR_CHECK_EN
  assign oob         = |m_addr[31:ADDR_WIDTH+2];
  assign unused_addr = ^m_addr[1:0];
`else
  assign oob         = 1'b0;
  assign unused_addr = ^{m_addr[31:ADDR_WIDTH+2], m_addr[1:0]};
`endif

  assign be = (acc_any && m_we && !oob) ? m_sel : '0;

  // Storage kept free of reset so it maps onto block RAM with byte enables.
  if (INIT_ZERO != 0) begin : g_mem
    logic [WB_DW-1:0] mem [SIZE] = '{default: '0};
    always_ff @(posedge clk_i) begin
      if (acc_any) begin
        rdata_q <= mem[idx];
      end
      for (int i = 0; i < int'(WB_SELW); i++) begin
        if (be[i]) begin
          mem[idx][8*i +: 8] <= m_data[8*i +: 8];
        end
      end
    end
  end else begin : g_mem
    logic [WB_DW-1:0] mem [SIZE];
    always_ff @(posedge clk_i) begin
      if (acc_any) begin
        rdata_q <= mem[idx];
      end
      for (int i = 0; i < int'(WB_SELW); i++) begin
        if (be[i]) begin
          mem[idx][8*i +: 8] <= m_data[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_q <= '0;
    end else begin
      ack_q <= accept & {NPORTS{~oob}};
    end
  end

`ifdef WB_NP_RAM_ADDR_CHECK_EN
  logic [NPORTS-1:0] err_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= '0;
    end else begin
      err_q <= accept & {NPORTS{oob}};
    end
  end
`endif

  // Responses are masked by the live cyc so an abandoned cycle never sees a stale ack.
  for (genvar p = 0; p < NPORTS; p++) begin : g_out
    assign wb[p].stall  = req[p] & ~accept[p];
    assign wb[p].ack    = ack_q[p] & wb[p].cyc;
    assign wb[p].data_s = (ack_q[p] && wb[p].cyc) ? rdata_q : '0;
`ifdef WB_NP_RAM_ADDR_CHECK_EN
    assign wb[p].err    = err_q[p] & wb[p].cyc;
`else
    assign wb[p].err    = 1'b0;
`endif
  end

endmodule

// File: tb/tb_wb_np_ram.sv
// Self-checking bench for wb_np_ram (SIZE=1024, NPORTS=4): directed scenarios with literal
// expectations plus randomized multi-port traffic against a behavioural memory model.
module tb_wb_np_ram;

  localparam int unsigned NP = 4;
  localparam int unsigned SZ = 1024;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NP-1:0] cyc, stb, we;
  logic [3:0]    sel [NP];
  logic [31:0]   adr [NP];
  logic [31:0]   dm  [NP];
  logic [NP-1:0] ack, err, stall;
  logic [31:0]   ds  [NP];

  int n_cmp  = 0;
  int n_fail = 0;

  wishbone_if wb_if [NP] (.clk_i(clk), .rst_ni(rst_n));

  for (genvar g = 0; g < NP; g++) begin : g_bridge
    assign wb_if[g].cyc    = cyc[g];
    assign wb_if[g].stb    = stb[g];
    assign wb_if[g].we     = we[g];
    assign wb_if[g].sel    = sel[g];
    assign wb_if[g].addr   = adr[g];
    assign wb_if[g].data_m = dm[g];
    assign ack[g]          = wb_if[g].ack;
    assign err[g]          = wb_if[g].err;
    assign stall[g]        = wb_if[g].stall;
    assign ds[g]           = wb_if[g].data_s;
  end

  wb_np_ram #(
    .SIZE      (SZ),
    .NPORTS    (NP),
    .INIT_ZERO (1)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .wb     (wb_if)
  );

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Behavioural model: memory image, rotating priority pointer, one pending response.
  logic [31:0] mem_m [SZ];
  int          ptr_m;
  bit          pend_v, pend_err;
  int          pend_p;
  logic [31:0] pend_d;

  always @(negedge clk) begin : model
    int          g, q;
    bit          e_ack, e_err, oob;
    logic [31:0] a;
    logic [9:0]  wi;
    if (!rst_n) begin
      for (int p = 0; p < NP; p++) begin
        check("rst_ack", ack[p], 0);
        check("rst_err", err[p], 0);
        check("rst_data", ds[p], 0);
      end
      ptr_m  = 0;
      pend_v = 0;
    end else begin
      g = -1;
      for (int k = 0; k < NP; k++) begin
        q = (ptr_m + k) % NP;
        if (g < 0 && cyc[q] && stb[q]) g = q;
      end
      for (int p = 0; p < NP; p++) begin
        e_ack = pend_v && !pend_err && pend_p == p && cyc[p];
        e_err = pend_v && pend_err && pend_p == p && cyc[p];
        check("m_ack", ack[p], e_ack);
        check("m_err", err[p], e_err);
        check("m_data", ds[p], e_ack ? pend_d : 32'h0);
        check("m_stall", stall[p], cyc[p] && stb[p] && p != g);
      end
      if (g >= 0) begin
        a  = adr[g];
        wi = a[11:2];
`ifdef WB_NP_RAM_ADDR_CHECK_EN
        oob = (a >= SZ * 4);
`else
        oob = 1'b0;
`endif
        pend_v   = 1;
        pend_p   = g;
        pend_err = oob;
        pend_d   = oob ? 32'h0 : mem_m[wi];
        if (!oob && we[g]) begin
          for (int b = 0; b < 4; b++) begin
            if (sel[g][b]) mem_m[wi][8*b +: 8] = dm[g][8*b +: 8];
          end
        end
        ptr_m = (g + 1) % NP;
      end else begin
        pend_v = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    for (int p = 0; p < NP; p++) begin
      cyc[p] = 1'b0;
      stb[p] = 1'b0;
      we[p]  = 1'b0;
      sel[p] = 4'h0;
      adr[p] = 32'h0;
      dm[p]  = 32'h0;
    end
  endtask

  // Single access on one port with literal expectations for the response cycle.
  task automatic access(input int p, input bit w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [31:0] exp_d, input bit exp_e,
                        input string name);
    cyc[p] = 1'b1;
    stb[p] = 1'b1;
    we[p]  = w;
    adr[p] = a;
    dm[p]  = d;
    sel[p] = s;
    step();
    stb[p] = 1'b0;
    we[p]  = 1'b0;
    @(negedge clk);
    check({name, "_ack"}, ack[p], !exp_e);
    check({name, "_err"}, err[p], exp_e);
    check({name, "_data"}, ds[p], exp_d);
    step();
    cyc[p] = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_all();
    for (int i = 0; i < SZ; i++) mem_m[i] = 32'h0;
    ptr_m  = 0;
    pend_v = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Basic write/read and byte-lane merge.
    access(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 0, "w_dead");
    access(0, 0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 0, "r_dead");
    access(0, 1, 32'h20, 32'h11223344, 4'hF, 32'h0, 0, "w_base");
    access(0, 1, 32'h20, 32'h000000AA, 4'h1, 32'h11223344, 0, "w_byte");
    access(0, 0, 32'h20, 32'h0, 4'hF, 32'h112233AA, 0, "r_byte");

    // Out-of-range address: error or alias depending on build.
`ifdef WB_NP_RAM_ADDR_CHECK_EN
    access(0, 1, 32'h1000, 32'h55, 4'hF, 32'h0, 1, "oob_w");
    access(0, 0, 32'h0, 32'h0, 4'hF, 32'h0, 0, "oob_w0");
`else
    access(0, 1, 32'h1000, 32'h55, 4'hF, 32'h0, 0, "alias_w");
    access(0, 0, 32'h0, 32'h0, 4'hF, 32'h55, 0, "alias_w0");
`endif

    // Two ports contending from reset: grants alternate 0,1,0,1.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    cyc[0] = 1'b1; stb[0] = 1'b1; adr[0] = 32'h10;
    cyc[1] = 1'b1; stb[1] = 1'b1; adr[1] = 32'h20;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("alt_stall0", stall[0], (i % 2) == 1);
      check("alt_stall1", stall[1], (i % 2) == 0);
      if (i > 0) begin
        check("alt_one_ack", $countones(ack), 1);
        check("alt_ack", ack[(i - 1) % 2], 1);
        check("alt_data", ds[(i - 1) % 2], ((i - 1) % 2 == 0) ? 32'hDEADBEEF : 32'h112233AA);
      end
      step();
    end
    idle_all();
    step();

    // Pointer at 2 with ports 1 and 3 requesting: 3 wins first, then 1.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    access(1, 0, 32'h20, 32'h0, 4'hF, 32'h112233AA, 0, "p1_solo");
    cyc[1] = 1'b1; stb[1] = 1'b1; adr[1] = 32'h20;
    cyc[3] = 1'b1; stb[3] = 1'b1; adr[3] = 32'h10;
    @(negedge clk);
    check("rr_stall3", stall[3], 0);
    check("rr_stall1", stall[1], 1);
    step();
    @(negedge clk);
    check("rr_ack3", ack[3], 1);
    check("rr_data3", ds[3], 32'hDEADBEEF);
    check("rr_stall1b", stall[1], 0);
    stb[3] = 1'b0;
    step();
    @(negedge clk);
    check("rr_ack1", ack[1], 1);
    check("rr_data1", ds[1], 32'h112233AA);
    idle_all();
    step();

    // Reset with an ack pending drops it; contents survive.
    access(0, 1, 32'h40, 32'hCAFEF00D, 4'hF, 32'h0, 0, "w_cafe");
    cyc[0] = 1'b1; stb[0] = 1'b1; adr[0] = 32'h40;
    step();
    stb[0] = 1'b0;
    rst_n  = 1'b0;
    @(negedge clk);
    check("rst_drop_ack", ack[0], 0);
    step();
    rst_n  = 1'b1;
    cyc[0] = 1'b0;
    access(0, 0, 32'h40, 32'h0, 4'hF, 32'hCAFEF00D, 0, "r_cafe");

    // Randomized traffic on all ports with occasional high address bits and resets.
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < NP; p++) begin
        cyc[p] = ($urandom_range(0, 9) != 0);
        stb[p] = cyc[p] && ($urandom_range(0, 2) != 0);
        we[p]  = 1'($urandom);
        sel[p] = 4'($urandom);
        dm[p]  = $urandom;
        adr[p] = 32'($urandom_range(0, 7)) << 2;
        if ($urandom_range(0, 7) == 0) adr[p] = adr[p] | (32'h1000 << $urandom_range(0, 19));
      end
      rst_n = ($urandom_range(0, 299) != 0);
      step();
    end
    idle_all();
    rst_n = 1'b1;
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_np_ram.md
WB_NP_RAM -- requirements
Module: wb_np_ram

Interface
REQ-001 Parameter SIZE, default 1024; memory depth in 32-bit words, power of two, 16 to 65536.
REQ-002 Parameter NPORTS, default 2; number of Wishbone slave ports, 1 to 8.
REQ-003 Parameter INIT_ZERO, default 1; 1 clears the array at elaboration, 0 leaves it uninitialised.
REQ-004 clk_i  input  1  single clock for all ports and the memory.
REQ-005 rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 wb[NPORTS]  wishbone_if.slave  array  pipelined Wishbone slave ports: addr 32, data_m 32, data_s 32, sel 4, we, cyc, stb, ack, stall, err.
REQ-007 The interface clk_i/rst_ni members are not used; all logic runs on clk_i and rst_ni.

Function
REQ-010 The memory is one single-port array, ADDR_WIDTH = $clog2(SIZE), word index addr[ADDR_WIDTH+1:2]; at most one access per cycle.
REQ-011 Port p requests when wb[p].cyc & wb[p].stb.
REQ-012 The round-robin arbiter grants exactly one requesting port per cycle; search starts at pointer ptr, ascending with wrap.
REQ-013 After a grant to port g, ptr becomes (g+1) mod NPORTS; with no grant, ptr holds.
REQ-014 wb[p].stall = request(p) & ~grant(p), combinational; a port not requesting sees stall=0.
REQ-015 A granted request is accepted in that cycle; the write applies at that clock edge to bytes where sel[i]=1.
REQ-016 ack for an accepted request asserts exactly one cycle later, for one cycle, on the same port.
REQ-017 data_s during ack holds the addressed word read before the write (read-before-write), for reads and writes alike.
REQ-018 A single requesting port is granted every cycle, so back-to-back pipelined accesses complete at one per cycle.
REQ-019 ack and err are masked by the current cycle's cyc; a master dropping cyc receives no stale ack, and the write remains committed.
REQ-020 data_s is 0 on every port that is not acking.

Reset
REQ-030 While rst_ni=0: every ack=0, err=0, ptr=0, and no write occurs.
REQ-031 Reset asserted mid-transaction discards pending acks; array contents are not cleared.
REQ-032 The first grant after reset goes to the lowest-index requesting port.

Configuration
REQ-040 Macro WB_NP_RAM_ADDR_CHECK_EN enables address range checking.
REQ-041 Defined: an accepted request with addr >= SIZE*4 performs no write and, one cycle later, asserts err instead of ack, with data_s=0.
REQ-042 Undefined: err is tied to 0, and upper address bits are ignored so addresses alias modulo SIZE words.

Structure
REQ-050 Package wb_ram_pkg holds WB_DW=32, WB_SELW=4, NPORTS_MAX=8 and typedef port_idx_t (logic [2:0]).
REQ-051 Sub-module wb_rr_arb (parameter N; inputs req[N], clk_i, rst_ni; outputs one-hot gnt[N]) contains the arbiter and ptr.
REQ-052 The array is inferable as single-port block RAM with byte enables.

Verification
REQ-060 NPORTS=2; port0 writes 0xDEADBEEF to 0x10 with sel=0xF, then reads 0x10 -> ack at T+1 each; the read returns 0xDEADBEEF.
REQ-061 Port0 writes 0x000000AA with sel=0x1 over 0x11223344 -> readback is 0x112233AA.
REQ-062 Both ports request every cycle from reset -> grants alternate 0,1,0,1; each stalled port sees stall=1; exactly one ack per cycle.
REQ-063 NPORTS=4, ports 1 and 3 request, ptr=2 -> port 3 is granted first, then port 1.
REQ-064 rst_ni pulled low while an ack is pending -> ack=0 immediately; data written before reset reads back intact.
REQ-065 With WB_NP_RAM_ADDR_CHECK_EN, SIZE=1024, a write to 0x1000 -> err=1 at T+1, ack=0; word 0 is unchanged. Without the macro, the same write lands in word 0.
